// File: rtl/sw_job_sequencer.sv
// Job front-end for one SW scoring core: clears the core, streams
// 64 reference / 48 query symbols, then returns the core result.
`timescale 1ns/1ps
module sw_job_sequencer #(
    parameter int WIDTH_SCORE     = 8,
    parameter int WIDTH_POS_REF   = 7,
    parameter int WIDTH_POS_QUERY = 6,
    parameter int ADDR_W          = 8,
    parameter int TIMEOUT         = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [ADDR_W-1:0]          job_ref_base,
    input  logic [ADDR_W-1:0]          job_qry_base,
    output logic                       ref_rd_en,
    output logic [ADDR_W-1:0]          ref_rd_addr,
    input  logic [1:0]                 ref_rd_data,
    output logic                       qry_rd_en,
    output logic [ADDR_W-1:0]          qry_rd_addr,
    input  logic [1:0]                 qry_rd_data,
    output logic                       core_rst,
    output logic                       core_valid,
    output logic [1:0]                 core_data_ref,
    output logic [1:0]                 core_data_query,
    input  logic                       core_finish,
    input  logic [WIDTH_SCORE-1:0]     core_max,
    input  logic [WIDTH_POS_REF-1:0]   core_pos_ref,
    input  logic [WIDTH_POS_QUERY-1:0] core_pos_query,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [WIDTH_SCORE-1:0]     res_max,
    output logic [WIDTH_POS_REF-1:0]   res_pos_ref,
    output logic [WIDTH_POS_QUERY-1:0] res_pos_query,
    output logic                       res_timeout,
    output logic                       busy
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TMO = WCNT_W'(TIMEOUT);
    localparam logic [5:0] K_LAST = 6'd63;
    localparam logic [5:0] K_QRY  = 6'd48;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_GAP,
        S_FETCH,
        S_DRAIN,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [ADDR_W-1:0]          r_ref_base;
    logic [ADDR_W-1:0]          r_qry_base;
    logic [5:0]                 r_k;
    logic [WCNT_W-1:0]          r_wcnt;
    logic                       r_core_rst;
    logic                       r_core_valid;
    logic                       r_qry_vld;
    logic [WIDTH_SCORE-1:0]     r_res_max;
    logic [WIDTH_POS_REF-1:0]   r_res_pos_ref;
    logic [WIDTH_POS_QUERY-1:0] r_res_pos_query;
    logic                       r_res_timeout;
    logic                       w_qry_on;
    logic                       w_tmo;

    assign w_qry_on = (r_k < K_QRY);
    assign w_tmo    = (r_wcnt == TMO);

    // State register; reset aborts any job in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the combinational strobes of each state.
    always_comb begin
        w_next    = r_state;
        job_ready = 1'b0;
        ref_rd_en = 1'b0;
        qry_rd_en = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) w_next = S_CLR;
            end
            S_CLR:   w_next = S_GAP;
            S_GAP:   w_next = S_FETCH;
            S_FETCH: begin
                ref_rd_en = 1'b1;
                qry_rd_en = w_qry_on;
                if (r_k == K_LAST) w_next = S_DRAIN;
            end
            S_DRAIN: w_next = S_WAIT;
            S_WAIT: begin
                if (core_finish || w_tmo) w_next = S_RESP;
            end
            S_RESP: begin
                if (res_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Job bases, fetch index and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ref_base <= '0;
            r_qry_base <= '0;
            r_k        <= '0;
            r_wcnt     <= '0;
        end else begin
            if (r_state == S_IDLE && job_valid) begin
                r_ref_base <= job_ref_base;
                r_qry_base <= job_qry_base;
                r_k        <= '0;
            end
            if (r_state == S_FETCH) r_k <= r_k + 6'd1;
            if (r_state == S_DRAIN) begin
                r_wcnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end

    // Core reset is registered so it is glitch-free; core_valid trails reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_core_rst   <= 1'b1;
            r_core_valid <= 1'b0;
            r_qry_vld    <= 1'b0;
        end else begin
            r_core_rst   <= (w_next == S_CLR);
            r_core_valid <= ref_rd_en;
            r_qry_vld    <= qry_rd_en;
        end
    end

    // Result capture in WAIT; a finish on the timeout cycle still wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res_max       <= '0;
            r_res_pos_ref   <= '0;
            r_res_pos_query <= '0;
            r_res_timeout   <= 1'b0;
        end else if (r_state == S_WAIT) begin
            if (core_finish) begin
                r_res_max       <= core_max;
                r_res_pos_ref   <= core_pos_ref;
                r_res_pos_query <= core_pos_query;
                r_res_timeout   <= 1'b0;
            end else if (w_tmo) begin
                r_res_max       <= '0;
                r_res_pos_ref   <= '0;
                r_res_pos_query <= '0;
                r_res_timeout   <= 1'b1;
            end
        end
    end

    assign ref_rd_addr     = r_ref_base + ADDR_W'(r_k);
    assign qry_rd_addr     = r_qry_base + ADDR_W'(r_k);
    assign core_rst        = r_core_rst;
    assign core_valid      = r_core_valid;
    assign core_data_ref   = r_core_valid ? ref_rd_data : 2'b00;
    assign core_data_query = (r_core_valid && r_qry_vld) ? qry_rd_data : 2'b00;
    assign res_valid       = (r_state == S_RESP);
    assign res_max         = r_res_max;
    assign res_pos_ref     = r_res_pos_ref;
    assign res_pos_query   = r_res_pos_query;
    assign res_timeout     = r_res_timeout;
    assign busy            = (r_state != S_IDLE);

endmodule
